// File: rtl/mac_pkg.sv
// Shared types, constants and IEEE-754 single-precision arithmetic for the
// vector MAC. The multiply and add helpers are the combinational datapath of
// every lane. Subnormals are flushed to zero, rounding is round-to-nearest-even,
// and NaN results are the canonical quiet NaN.
package mac_pkg;

    localparam int unsigned SINGLE    = 32;
    localparam int unsigned DEF_LANES = 4;
    localparam int unsigned DEF_LEN_W = 16;

    localparam logic [SINGLE-1:0] QNAN = 32'h7FC0_0000;

    typedef struct packed {
        logic [SINGLE-1:0] value;
        logic              valid;
    } scalar_t;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DRAIN,
        DONE
    } mac_state_e;

    function automatic logic [SINGLE-1:0] fp_mul(input logic [SINGLE-1:0] a,
                                                 input logic [SINGLE-1:0] b);
        logic        s;
        logic [7:0]  ea;
        logic [7:0]  eb;
        logic [47:0] p;
        logic [23:0] m;
        logic        g;
        logic        st;
        int          e;
        s  = a[31] ^ b[31];
        ea = a[30:23];
        eb = b[30:23];
        p  = '0;
        m  = '0;
        g  = 1'b0;
        st = 1'b0;
        e  = 0;
        if ((ea == 8'hFF && a[22:0] != '0) || (eb == 8'hFF && b[22:0] != '0))
            return QNAN;
        if (ea == 8'hFF || eb == 8'hFF) begin
            if (ea == 8'h00 || eb == 8'h00)
                return QNAN;
            return {s, 8'hFF, 23'd0};
        end
        if (ea == 8'h00 || eb == 8'h00)
            return {s, 31'd0};
        p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        e = int'(ea) + int'(eb) - 127;
        if (p[47]) begin
            m  = {1'b0, p[46:24]};
            g  = p[23];
            st = |p[22:0];
            e  = e + 1;
        end else begin
            m  = {1'b0, p[45:23]};
            g  = p[22];
            st = |p[21:0];
        end
        if (g && (st || m[0]))
            m = m + 24'd1;
        if (m[23]) begin
            m = '0;
            e = e + 1;
        end
        if (e >= 255)
            return {s, 8'hFF, 23'd0};
        if (e <= 0)
            return {s, 31'd0};
        return {s, e[7:0], m[22:0]};
    endfunction

    function automatic logic [SINGLE-1:0] fp_add(input logic [SINGLE-1:0] a,
                                                 input logic [SINGLE-1:0] b);
        logic [SINGLE-1:0] x;
        logic [SINGLE-1:0] y;
        logic [26:0]       mx;
        logic [26:0]       my;
        logic [26:0]       sh;
        logic [27:0]       sum;
        logic [26:0]       v;
        logic [24:0]       m;
        logic              s;
        int                d;
        int                e;
        x   = a;
        y   = b;
        mx  = '0;
        my  = '0;
        sh  = '0;
        sum = '0;
        v   = '0;
        m   = '0;
        s   = 1'b0;
        d   = 0;
        e   = 0;
        if ((a[30:23] == 8'hFF && a[22:0] != '0) || (b[30:23] == 8'hFF && b[22:0] != '0))
            return QNAN;
        if (a[30:23] == 8'hFF) begin
            if (b[30:23] == 8'hFF && a[31] != b[31])
                return QNAN;
            return a;
        end
        if (b[30:23] == 8'hFF)
            return b;
        if (a[30:23] == 8'h00 && b[30:23] == 8'h00)
            return {a[31] & b[31], 31'd0};
        if (a[30:23] == 8'h00)
            return b;
        if (b[30:23] == 8'h00)
            return a;
        // x carries the larger magnitude so the aligned difference is never negative
        if (a[30:0] < b[30:0]) begin
            x = b;
            y = a;
        end
        s  = x[31];
        e  = int'(x[30:23]);
        d  = int'(x[30:23]) - int'(y[30:23]);
        mx = {1'b1, x[22:0], 3'b000};
        my = {1'b1, y[22:0], 3'b000};
        if (d >= 27) begin
            sh = 27'd1;
        end else begin
            sh = my >> d;
            if ((my & ~({27{1'b1}} << d)) != '0)
                sh[0] = 1'b1;
        end
        if (x[31] == y[31]) begin
            sum = {1'b0, mx} + {1'b0, sh};
            if (sum[27]) begin
                v    = sum[27:1];
                v[0] = sum[1] | sum[0];
                e    = e + 1;
            end else begin
                v = sum[26:0];
            end
        end else begin
            v = mx - sh;
            if (v == '0)
                return '0;
            for (int unsigned i = 0; i < 26; i++) begin
                if (!v[26]) begin
                    v = v << 1;
                    e = e - 1;
                end
            end
        end
        m = {1'b0, v[26:3]};
        if (v[2] && (v[1] || v[0] || v[3]))
            m = m + 25'd1;
        if (m[24]) begin
            m = m >> 1;
            e = e + 1;
        end
        if (e >= 255)
            return {s, 8'hFF, 23'd0};
        if (e <= 0)
            return {s, 31'd0};
        return {s, e[7:0], m[22:0]};
    endfunction

endpackage

// File: rtl/mac_lane.sv
// One MAC lane: multiplier feeding a stage-1 product register, then an adder
// feeding the accumulator register. Sequencing comes from the top-level FSM.
module mac_lane
    import mac_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic [SINGLE-1:0] init_val,
    input  logic              ld,
    input  logic              acc_en,
    input  logic [SINGLE-1:0] a,
    input  logic [SINGLE-1:0] b,
    output logic [SINGLE-1:0] acc
);

    logic [SINGLE-1:0] prod_q;

    // Stage 1: capture the product of an accepted beat
    always_ff @(posedge clk) begin
        if (rst)
            prod_q <= '0;
        else if (ld)
            prod_q <= fp_mul(a, b);
    end

    // Stage 2: initialise on start, otherwise fold in each valid product
    always_ff @(posedge clk) begin
        if (rst)
            acc <= '0;
        else if (clr)
            acc <= init_val;
        else if (acc_en)
            acc <= fp_add(acc, prod_q);
    end

endmodule

// File: rtl/mac_vec_acc.sv
// LANES-wide floating-point multiply-accumulate with a shared control FSM.
// Optional feature macro: MAC_VEC_BIAS_EN (adds a bias port used as the
// accumulator initial value).
module mac_vec_acc
    import mac_pkg::*;
#(
    parameter int unsigned LANES = DEF_LANES,
    parameter int unsigned WIDTH = SINGLE,
    parameter int unsigned LEN_W = DEF_LEN_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [LEN_W-1:0]       len,
`ifdef MAC_VEC_BIAS_EN
    input  logic [LANES*WIDTH-1:0] bias,
`endif
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] data,
    input  logic [LANES*WIDTH-1:0] weight,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_data,
    output logic                   busy
);

    mac_state_e       state;
    logic [LEN_W-1:0] cnt;
    logic             p_valid;
    logic             p_last;
    logic             accept;
    logic             clr_acc;
    logic [LANES*WIDTH-1:0] init_vec;

    assign accept  = (state == ACC) && in_valid;
    assign clr_acc = (state == IDLE) && start;

`ifdef MAC_VEC_BIAS_EN
    assign init_vec = bias;
`else
    assign init_vec = '0;
`endif

    // Control FSM, beat counter, pipeline flags and registered handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            p_valid   <= 1'b0;
            p_last    <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            p_valid <= accept;
            p_last  <= accept && (cnt == LEN_W'(1));
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (len != '0) begin
                            cnt      <= len;
                            in_ready <= 1'b1;
                            state    <= ACC;
                        end else begin
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                ACC: begin
                    if (in_valid) begin
                        cnt <= cnt - LEN_W'(1);
                        if (cnt == LEN_W'(1)) begin
                            in_ready <= 1'b0;
                            state    <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (p_valid && p_last) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            mac_lane u_lane (
                .clk      (clk),
                .rst      (rst),
                .clr      (clr_acc),
                .init_val (init_vec[gi*WIDTH +: WIDTH]),
                .ld       (accept),
                .acc_en   (p_valid),
                .a        (data[gi*WIDTH +: WIDTH]),
                .b        (weight[gi*WIDTH +: WIDTH]),
                .acc      (out_data[gi*WIDTH +: WIDTH])
            );
        end
    endgenerate

endmodule

// File: tb/tb_mac_vec_acc.sv
// Directed, table-driven bench for mac_vec_acc (LANES=4) plus hand-written
// sequences for output back-pressure, zero-length and mid-operation reset.
module tb_mac_vec_acc;

    localparam int unsigned LANES = 4;
    localparam int unsigned W     = 32;
    localparam int unsigned LEN_W = 16;
    localparam int unsigned NV    = 5;

    logic                   clk;
    logic                   rst;
    logic                   start;
    logic [LEN_W-1:0]       len;
    logic                   in_valid;
    logic                   in_ready;
    logic [LANES*W-1:0]     data;
    logic [LANES*W-1:0]     weight;
    logic                   out_valid;
    logic                   out_ready;
    logic [LANES*W-1:0]     out_data;
    logic                   busy;
`ifdef MAC_VEC_BIAS_EN
    logic [LANES*W-1:0]     bias;
`endif

    int checks;
    int failures;

    typedef struct {
        int unsigned        len;
        int unsigned        gap;
        logic [3:0][127:0]  d;
        logic [3:0][127:0]  w;
        logic [127:0]       exp_nb;
        logic [127:0]       exp_b;
    } vec_t;

    vec_t tv[NV];

    mac_vec_acc #(.LANES(LANES), .WIDTH(W), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
`ifdef MAC_VEC_BIAS_EN
        .bias      (bias),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data      (data),
        .weight    (weight),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] rep(input logic [31:0] x);
        return {x, x, x, x};
    endfunction

    function automatic logic [127:0] expv(input int idx);
`ifdef MAC_VEC_BIAS_EN
        return tv[idx].exp_b;
`else
        return tv[idx].exp_nb;
`endif
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input int idx, input bit handshake);
        start = 1'b1;
        len   = tv[idx].len[LEN_W-1:0];
        tick();
        start = 1'b0;
        chk("busy_after_start", {127'd0, busy}, 128'd1);
        chk("in_ready_acc", {127'd0, in_ready}, 128'd1);
        for (int unsigned bt = 0; bt < tv[idx].len; bt++) begin
            if (bt > 0) begin
                for (int unsigned g = 0; g < tv[idx].gap; g++) begin
                    in_valid = 1'b0;
                    tick();
                    chk("in_ready_gap", {127'd0, in_ready}, 128'd1);
                end
            end
            in_valid = 1'b1;
            data     = tv[idx].d[bt];
            weight   = tv[idx].w[bt];
            tick();
            in_valid = 1'b0;
            data     = '0;
            weight   = '0;
        end
        chk("drain_out_valid", {127'd0, out_valid}, 128'd0);
        chk("drain_in_ready", {127'd0, in_ready}, 128'd0);
        tick();
        chk("out_valid_latency", {127'd0, out_valid}, 128'd1);
        chk("out_data", out_data, expv(idx));
        if (handshake) begin
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            chk("post_hs_out_valid", {127'd0, out_valid}, 128'd0);
            chk("post_hs_busy", {127'd0, busy}, 128'd0);
        end
    endtask

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        checks   = 0;
        failures = 0;

        // 1.0*2 + 2.0*2 + 3.0*2 on every lane, back-to-back
        tv[0].len = 3; tv[0].gap = 0;
        tv[0].d = '0; tv[0].w = '0;
        tv[0].d[0] = rep(32'h3F80_0000); tv[0].w[0] = rep(32'h4000_0000);
        tv[0].d[1] = rep(32'h4000_0000); tv[0].w[1] = rep(32'h4000_0000);
        tv[0].d[2] = rep(32'h4040_0000); tv[0].w[2] = rep(32'h4000_0000);
        tv[0].exp_nb = rep(32'h4140_0000);
        tv[0].exp_b  = rep(32'h4148_0000);
        // Same stimulus with two idle cycles between beats
        tv[1] = tv[0];
        tv[1].gap = 2;
        // Distinct per-lane operands (lane3..lane0): 2.0, 8.0, 7.0, 5.0
        tv[2].len = 2; tv[2].gap = 0;
        tv[2].d = '0; tv[2].w = '0;
        tv[2].d[0] = {32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h3F80_0000};
        tv[2].w[0] = {32'hBF80_0000, 32'h4000_0000, 32'h4000_0000, 32'h3F80_0000};
        tv[2].d[1] = {32'h4040_0000, 32'h4000_0000, 32'h3F80_0000, 32'h4000_0000};
        tv[2].w[1] = {32'h3F80_0000, 32'h4000_0000, 32'h3F80_0000, 32'h4000_0000};
        tv[2].exp_nb = {32'h4000_0000, 32'h4100_0000, 32'h40E0_0000, 32'h40A0_0000};
        tv[2].exp_b  = {32'h4020_0000, 32'h4108_0000, 32'h40F0_0000, 32'h40B0_0000};
        // Single beat 3.0*3.0 = 9.0
        tv[3].len = 1; tv[3].gap = 0;
        tv[3].d = '0; tv[3].w = '0;
        tv[3].d[0] = rep(32'h4040_0000); tv[3].w[0] = rep(32'h4040_0000);
        tv[3].exp_nb = rep(32'h4110_0000);
        tv[3].exp_b  = rep(32'h4118_0000);
        // Four beats of 0.5*0.5 with single-cycle gaps = 1.0
        tv[4].len = 4; tv[4].gap = 1;
        tv[4].d = '0; tv[4].w = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            tv[4].d[k] = rep(32'h3F00_0000);
            tv[4].w[k] = rep(32'h3F00_0000);
        end
        tv[4].exp_nb = rep(32'h3F80_0000);
        tv[4].exp_b  = rep(32'h3FC0_0000);

        rst       = 1'b1;
        start     = 1'b0;
        len       = '0;
        in_valid  = 1'b0;
        data      = '0;
        weight    = '0;
        out_ready = 1'b0;
`ifdef MAC_VEC_BIAS_EN
        bias      = rep(32'h3F00_0000);
`endif
        tick();
        tick();
        rst = 1'b0;
        chk("reset_in_ready", {127'd0, in_ready}, 128'd0);
        chk("reset_out_valid", {127'd0, out_valid}, 128'd0);
        chk("reset_busy", {127'd0, busy}, 128'd0);
        chk("reset_out_data", out_data, 128'd0);
        tick();

        for (int i = 0; i < int'(NV); i++)
            run_op(i, 1'b1);

        // Back-pressure: result held, start ignored while pending
        run_op(0, 1'b0);
        for (int unsigned c = 0; c < 5; c++) begin
            start = 1'b1;
            len   = 16'd1;
            tick();
            chk("hold_out_data", out_data, expv(0));
            chk("hold_out_valid", {127'd0, out_valid}, 128'd1);
            chk("hold_in_ready", {127'd0, in_ready}, 128'd0);
        end
        start     = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("hold_release_busy", {127'd0, busy}, 128'd0);
        chk("hold_release_valid", {127'd0, out_valid}, 128'd0);
        tick();
        chk("no_queued_start", {127'd0, busy}, 128'd0);

        // Zero-length operation goes straight to DONE with the initial value
        start = 1'b1;
        len   = '0;
        tick();
        start = 1'b0;
        chk("len0_out_valid", {127'd0, out_valid}, 128'd1);
        chk("len0_in_ready", {127'd0, in_ready}, 128'd0);
`ifdef MAC_VEC_BIAS_EN
        chk("len0_out_data", out_data, rep(32'h3F00_0000));
`else
        chk("len0_out_data", out_data, 128'd0);
`endif
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("len0_hs_busy", {127'd0, busy}, 128'd0);

        // Reset after two of four beats abandons the operation
        start = 1'b1;
        len   = 16'd4;
        tick();
        start = 1'b0;
        for (int unsigned bt = 0; bt < 2; bt++) begin
            in_valid = 1'b1;
            data     = tv[4].d[bt];
            weight   = tv[4].w[bt];
            tick();
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_out_valid", {127'd0, out_valid}, 128'd0);
        chk("midrst_in_ready", {127'd0, in_ready}, 128'd0);
        chk("midrst_busy", {127'd0, busy}, 128'd0);
        chk("midrst_out_data", out_data, 128'd0);
        tick();
        chk("midrst_no_result", {127'd0, out_valid}, 128'd0);
        run_op(3, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
